// File: rtl/dioptase_pkg.sv
// Shared definitions for the Dioptase execute stage: opcodes, ALU sub-ops,
// shifter kinds and flag bit positions.
package dioptase_pkg;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_ALUI = 5'd1;
    localparam logic [4:0] OP_LUI  = 5'd2;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_NAND = 5'd1,
        ALU_OR   = 5'd2,
        ALU_NOR  = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_XNOR = 5'd5,
        ALU_NOT  = 5'd6,
        ALU_LSL  = 5'd7,
        ALU_LSR  = 5'd8,
        ALU_ASR  = 5'd9,
        ALU_ROTL = 5'd10,
        ALU_ROTR = 5'd11,
        ALU_LSLC = 5'd12,
        ALU_LSRC = 5'd13,
        ALU_ADD  = 5'd14,
        ALU_ADDC = 5'd15,
        ALU_SUB  = 5'd16,
        ALU_SUBB = 5'd17
    } alu_op_e;

    typedef enum logic [2:0] {
        SH_LSL  = 3'd0,
        SH_LSR  = 3'd1,
        SH_ASR  = 3'd2,
        SH_ROTL = 3'd3,
        SH_ROTR = 3'd4,
        SH_LSLC = 3'd5,
        SH_LSRC = 3'd6
    } shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter/rotator: vacated bits come from a per-kind fill word, and
// cout is the last bit pushed off the end (0 for a zero amount).
module alu_shifter
    import dioptase_pkg::*;
(
    input  logic [31:0] value,
    input  logic [4:0]  amount,
    input  logic [2:0]  kind,
    input  logic        cin,
    output logic [31:0] shifted,
    output logic        cout
);

    logic [31:0] fill;
    logic [5:0]  inv;
    logic        left;
    logic        zero;

    assign inv  = 6'd32 - {1'b0, amount};
    assign zero = (amount == 5'd0);
    assign left = (kind == SH_LSL) || (kind == SH_ROTL) || (kind == SH_LSLC);

    always_comb begin
        case (kind)
            SH_LSL, SH_LSR:   fill = '0;
            SH_ASR:           fill = {32{value[31]}};
            SH_ROTL, SH_ROTR: fill = value;
            default:          fill = {32{cin}};
        endcase
    end

    // The fill word supplies the top (right shift) or bottom (left shift)
    // amount bits; rotates use the value itself as fill.
    always_comb begin
        shifted = value;
        cout    = 1'b0;
        if (!zero) begin
            if (left) begin
                shifted = (value << amount) | (fill >> inv);
                cout    = value[inv[4:0]];
            end else begin
                shifted = (value >> amount) | (fill << inv);
                cout    = value[amount - 5'd1];
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Execute-stage integer ALU with the architectural {O,S,Z,C} flag register.
// Carry-consuming ops read the registered C, never this cycle's new C.
module alu_unit
    import dioptase_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode,
    input  logic [4:0]  alu_op,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic        bubble,
    input  logic [31:0] flags_restore,
    input  logic        rfe_in_wb,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    alu_op_e     op;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_o;
    logic [31:0] b_op;
    logic        add_cin;
    logic [32:0] sum;
    logic [2:0]  sh_kind;
    logic [31:0] sh_out;
    logic        sh_c;
    logic [3:0]  new_flags;
    logic        is_alu;
    logic        unused_restore;

    assign op             = alu_op_e'(alu_op);
    assign is_alu         = (opcode == OP_ALU) || (opcode == OP_ALUI);
    assign unused_restore = ^flags_restore[31:4];

    // Subtraction is lhs + ~rhs + cin so carry-out means "no borrow".
    always_comb begin
        b_op    = rhs;
        add_cin = 1'b0;
        case (op)
            ALU_ADDC: add_cin = flags[FLAG_C];
            ALU_SUB:  begin b_op = ~rhs; add_cin = 1'b1; end
            ALU_SUBB: begin b_op = ~rhs; add_cin = flags[FLAG_C]; end
            default:  ;
        endcase
        sum = {1'b0, lhs} + {1'b0, b_op} + {32'd0, add_cin};
    end

    always_comb begin
        case (op)
            ALU_LSR:  sh_kind = SH_LSR;
            ALU_ASR:  sh_kind = SH_ASR;
            ALU_ROTL: sh_kind = SH_ROTL;
            ALU_ROTR: sh_kind = SH_ROTR;
            ALU_LSLC: sh_kind = SH_LSLC;
            ALU_LSRC: sh_kind = SH_LSRC;
            default:  sh_kind = SH_LSL;
        endcase
    end

    alu_shifter u_shifter (
        .value   (lhs),
        .amount  (rhs[4:0]),
        .kind    (sh_kind),
        .cin     (flags[FLAG_C]),
        .shifted (sh_out),
        .cout    (sh_c)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (op)
            ALU_AND:  alu_res = lhs & rhs;
            ALU_NAND: alu_res = ~(lhs & rhs);
            ALU_OR:   alu_res = lhs | rhs;
            ALU_NOR:  alu_res = ~(lhs | rhs);
            ALU_XOR:  alu_res = lhs ^ rhs;
            ALU_XNOR: alu_res = ~(lhs ^ rhs);
            ALU_NOT:  alu_res = ~rhs;
            ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROTL, ALU_ROTR, ALU_LSLC, ALU_LSRC: begin
                alu_res = sh_out;
                alu_c   = sh_c;
            end
            ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBB: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_o   = (lhs[31] == b_op[31]) && (sum[31] != lhs[31]);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ALU, OP_ALUI: result = alu_res;
            OP_LUI:          result = rhs;
            default:         result = lhs + rhs;
        endcase
    end

    always_comb begin
        new_flags         = '0;
        new_flags[FLAG_C] = alu_c;
        new_flags[FLAG_Z] = (alu_res == 32'd0);
        new_flags[FLAG_S] = alu_res[31];
        new_flags[FLAG_O] = alu_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= '0;
        else if (rfe_in_wb)
            flags <= flags_restore[3:0];
        else if (!bubble && is_alu)
            flags <= new_flags;
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench: each issued cycle queues the expected result and the
// flag register value visible in that cycle; a negedge monitor compares them.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        bubble;
    logic [31:0] flags_restore;
    logic        rfe_in_wb;
    logic [31:0] result;
    logic [3:0]  flags;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .alu_op        (alu_op),
        .lhs           (lhs),
        .rhs           (rhs),
        .bubble        (bubble),
        .flags_restore (flags_restore),
        .rfe_in_wb     (rfe_in_wb),
        .result        (result),
        .flags         (flags)
    );

    // Monitor: combinational result and registered flags are both stable mid-cycle.
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (result !== e.res) begin
                bad++;
                $display("FAIL %s result: got %h want %h", e.name, result, e.res);
            end
            total++;
            if (flags !== e.flg) begin
                bad++;
                $display("FAIL %s flags: got %b want %b", e.name, flags, e.flg);
            end
        end
    end

    task automatic step(input string nm, input logic [4:0] opc, input logic [4:0] aop,
                        input logic [31:0] l, input logic [31:0] r, input logic bub,
                        input logic rfe, input logic [31:0] rest,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg_now);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = opc; alu_op = aop; lhs = l; rhs = r;
        bubble = bub; rfe_in_wb = rfe; flags_restore = rest;
        e.name = nm; e.res = exp_res; e.flg = exp_flg_now;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 5'd0; alu_op = 5'd0; lhs = '0; rhs = '0;
        bubble = 1'b1; rfe_in_wb = 1'b0; flags_restore = '0;
        #22;
        rst_n = 1'b1;

        // flags column is OSZC as held during that cycle (from the previous edge)
        step("sub_eq",    5'd1, 5'd16, 32'd5,        32'd5,        1'b0, 1'b0, 32'd0, 32'd0,          4'b0000);
        step("sub_lt",    5'd1, 5'd16, 32'h10,       32'h20,       1'b0, 1'b0, 32'd0, 32'hFFFFFFF0,   4'b0011);
        step("add_ovf",   5'd0, 5'd14, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0, 32'h80000000,   4'b0100);
        step("add_carry", 5'd0, 5'd14, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0, 32'd0,          4'b1100);
        step("addc",      5'd0, 5'd15, 32'd1,        32'd2,        1'b0, 1'b0, 32'd0, 32'd4,          4'b0011);
        step("set_c",     5'd0, 5'd14, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0, 32'd0,          4'b0000);
        step("lslc",      5'd0, 5'd12, 32'h80000001, 32'd1,        1'b0, 1'b0, 32'd0, 32'h00000003,   4'b0011);
        step("bubble",    5'd1, 5'd16, 32'd7,        32'd7,        1'b1, 1'b0, 32'd0, 32'd0,          4'b0001);
        step("mem_add",   5'd3, 5'd16, 32'h100,      32'd8,        1'b0, 1'b0, 32'd0, 32'h108,        4'b0001);
        step("lui",       5'd2, 5'd16, 32'd5,        32'hABCD0000, 1'b0, 1'b0, 32'd0, 32'hABCD0000,   4'b0001);
        step("rfe",       5'd1, 5'd16, 32'd9,        32'd9,        1'b0, 1'b1, 32'hA, 32'd0,          4'b0001);
        step("lsr",       5'd0, 5'd8,  32'd3,        32'd1,        1'b0, 1'b0, 32'd0, 32'd1,          4'b1010);
        step("asr",       5'd0, 5'd9,  32'h80000000, 32'd4,        1'b0, 1'b0, 32'd0, 32'hF8000000,   4'b0001);
        step("rotr",      5'd0, 5'd11, 32'd1,        32'd1,        1'b0, 1'b0, 32'd0, 32'h80000000,   4'b0100);
        step("subb",      5'd0, 5'd17, 32'd10,       32'd3,        1'b0, 1'b0, 32'd0, 32'd7,          4'b0101);
        step("lsl_zero",  5'd0, 5'd7,  32'h1234,     32'h20,       1'b0, 1'b0, 32'd0, 32'h1234,       4'b0001);
        step("op_20",     5'd0, 5'd20, 32'h1234,     32'h5678,     1'b0, 1'b0, 32'd0, 32'd0,          4'b0000);
        step("or",        5'd0, 5'd2,  32'h80000000, 32'd1,        1'b0, 1'b0, 32'd0, 32'h80000001,   4'b0010);
        step("final",     5'd0, 5'd0,  32'd0,        32'd0,        1'b1, 1'b0, 32'd0, 32'd0,          4'b0100);

        begin : drain
            int n;
            n = 0;
            while (sb.size() > 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending want 0", sb.size());
            end
        end

        // Asynchronous reset mid-cycle, well away from any clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (flags !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset flags: got %b want 0000", flags);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
